// File: rtl/cci_mpf_prim_ram_rd_stream.sv
// Valid/ready read front end for a fixed-latency RAM with an in-order, credit-sized response buffer.
// Optional request tag pass-through is enabled by defining CCI_MPF_PRIM_RAM_RD_STREAM_TAG_EN.
module cci_mpf_prim_ram_rd_stream #(
  parameter int N_ENTRIES        = 32,
  parameter int N_DATA_BITS      = 64,
  parameter int RAM_READ_LATENCY = 1,
  parameter int BUF_ENTRIES      = RAM_READ_LATENCY + 2,
  parameter int N_TAG_BITS       = 8
) (
  input  logic                         clk,
  input  logic                         reset,

  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [$clog2(N_ENTRIES)-1:0] req_addr,

  output logic [$clog2(N_ENTRIES)-1:0] ram_raddr,
  input  logic [N_DATA_BITS-1:0]       ram_rdata,

`ifdef CCI_MPF_PRIM_RAM_RD_STREAM_TAG_EN
  input  logic [N_TAG_BITS-1:0]        req_tag,
  output logic [N_TAG_BITS-1:0]        rsp_tag,
`endif

  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [N_DATA_BITS-1:0]       rsp_data,
  output logic                         idle
);

  localparam int LAT   = RAM_READ_LATENCY;
  localparam int PTR_W = (BUF_ENTRIES > 1) ? $clog2(BUF_ENTRIES) : 1;
  localparam int CNT_W = $clog2(BUF_ENTRIES + 1);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BUF_ENTRIES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_ENTRIES - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Parameter sanity checks resolved at elaboration.
  if (RAM_READ_LATENCY < 1) begin : g_bad_latency
    $fatal(1, "RAM_READ_LATENCY must be >= 1");
  end
  if (BUF_ENTRIES < RAM_READ_LATENCY + 1) begin : g_bad_buf
    $fatal(1, "BUF_ENTRIES must be >= RAM_READ_LATENCY+1");
  end
  if (N_TAG_BITS < 1) begin : g_bad_tag
    $fatal(1, "N_TAG_BITS must be >= 1");
  end

  logic [CNT_W-1:0] credits_used;
  logic [CNT_W-1:0] buf_count;
  logic [LAT-1:0]   pipe_valid;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  logic [N_DATA_BITS-1:0] buf_data [BUF_ENTRIES];

  logic accept;
  logic pop;
  logic push;

  // Credits are registered only, so a pop frees its slot for requests one cycle later.
  assign req_ready = !reset && (credits_used < CNT_MAX);
  assign accept    = req_valid && req_ready;
  assign ram_raddr = req_addr;

  assign push      = pipe_valid[LAT-1];
  assign rsp_valid = (buf_count != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_data  = buf_data[head];
  assign idle      = (credits_used == '0);

  // NOTE: all sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      credits_used <= '0;
      buf_count    <= '0;
      pipe_valid   <= '0;
      head         <= '0;
      tail         <= '0;
    end else begin
      pipe_valid[0] <= accept;
      for (int i = 1; i < LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
      end

      if (push) tail <= (tail == PTR_LAST) ? '0 : tail + PTR_ONE;
      if (pop)  head <= (head == PTR_LAST) ? '0 : head + PTR_ONE;

      case ({push, pop})
        2'b10:   buf_count <= buf_count + CNT_ONE;
        2'b01:   buf_count <= buf_count - CNT_ONE;
        default: buf_count <= buf_count;
      endcase

      // A read holds its credit from acceptance until its response is popped.
      case ({accept, pop})
        2'b10:   credits_used <= credits_used + CNT_ONE;
        2'b01:   credits_used <= credits_used - CNT_ONE;
        default: credits_used <= credits_used;
      endcase
    end
  end

  // NOTE: payload storage has no reset; head/tail/count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) buf_data[tail] <= ram_rdata;
  end

`ifdef CCI_MPF_PRIM_RAM_RD_STREAM_TAG_EN
  logic [N_TAG_BITS-1:0] pipe_tag [LAT];
  logic [N_TAG_BITS-1:0] buf_tag  [BUF_ENTRIES];

  always_ff @(posedge clk) begin
    pipe_tag[0] <= req_tag;
    for (int i = 1; i < LAT; i++) begin
      pipe_tag[i] <= pipe_tag[i-1];
    end
    if (push) buf_tag[tail] <= pipe_tag[LAT-1];
  end

  assign rsp_tag = buf_tag[head];
`endif

  // Every in-flight read owns a credit, so a push can never meet a full buffer.
  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    !(push && (buf_count == CNT_MAX)))
    else $error("push into full response buffer");

endmodule

// File: tb/tb_cci_mpf_prim_ram_rd_stream.sv
// Randomized self-checking bench for cci_mpf_prim_ram_rd_stream against an in-order queue model.
// Tag checks are compiled in when CCI_MPF_PRIM_RAM_RD_STREAM_TAG_EN is defined.
module tb_cci_mpf_prim_ram_rd_stream;

  localparam int N_ENTRIES   = 32;
  localparam int N_DATA_BITS = 64;
  localparam int LAT         = 2;
  localparam int BUF         = 4;
  localparam int N_TAG_BITS  = 8;
  localparam int AW          = $clog2(N_ENTRIES);

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   req_valid;
  logic                   req_ready;
  logic [AW-1:0]          req_addr;
  logic [AW-1:0]          ram_raddr;
  logic [N_DATA_BITS-1:0] ram_rdata;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [N_DATA_BITS-1:0] rsp_data;
  logic                   idle;
  logic [N_TAG_BITS-1:0]  req_tag_v;
  logic [N_TAG_BITS-1:0]  rsp_tag_v;

  cci_mpf_prim_ram_rd_stream #(
    .N_ENTRIES        (N_ENTRIES),
    .N_DATA_BITS      (N_DATA_BITS),
    .RAM_READ_LATENCY (LAT),
    .BUF_ENTRIES      (BUF),
    .N_TAG_BITS       (N_TAG_BITS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata),
`ifdef CCI_MPF_PRIM_RAM_RD_STREAM_TAG_EN
    .req_tag   (req_tag_v),
    .rsp_tag   (rsp_tag_v),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .idle      (idle)
  );

`ifndef CCI_MPF_PRIM_RAM_RD_STREAM_TAG_EN
  assign rsp_tag_v = '0;
`endif

  always #5 clk = ~clk;

  // RAM with a fixed LAT-cycle read latency.
  logic [N_DATA_BITS-1:0] ram     [N_ENTRIES];
  logic [N_DATA_BITS-1:0] rd_pipe [LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= ram[ram_raddr];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_rdata = rd_pipe[LAT-1];

  typedef struct {
    logic [N_DATA_BITS-1:0] data;
    logic [N_TAG_BITS-1:0]  tag;
    int                     cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t s_exp;
  int   cyc;
  int   n_tests;
  int   n_fail;

  logic                   s_rdy, s_vld, s_idle, s_acc, s_pop, s_spur;
  logic                   s_exp_rdy, s_exp_idle;
  logic [N_DATA_BITS-1:0] s_data;
  logic [N_TAG_BITS-1:0]  s_tag;
  logic [AW-1:0]          s_raddr;

  // One clock cycle: sample at negedge, advance the reference model, drive window opens #1 after posedge.
  task automatic tick();
    @(negedge clk);
    s_rdy      = req_ready;
    s_vld      = rsp_valid;
    s_idle     = idle;
    s_data     = rsp_data;
    s_tag      = rsp_tag_v;
    s_raddr    = ram_raddr;
    s_exp_rdy  = !reset && (exp_q.size() < BUF);
    s_exp_idle = (exp_q.size() == 0);
    s_acc      = req_valid && req_ready;
    s_pop      = rsp_valid && rsp_ready;
    s_spur     = 1'b0;
    if (s_pop) begin
      if (exp_q.size() == 0) begin
        s_spur = 1'b1;
        s_exp  = '{data: '0, tag: '0, cyc: 0};
      end else begin
        s_exp = exp_q.pop_front();
      end
    end
    if (s_acc) exp_q.push_back('{data: ram[req_addr], tag: req_tag_v, cyc: cyc});
    if (reset) exp_q.delete();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; req_addr = '0; req_tag_v = '0;
    tick();
    tick();
    n_tests++; if (s_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=0", s_rdy); end
    n_tests++; if (s_vld !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", s_vld); end
    n_tests++; if (s_idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got=%b exp=1", s_idle); end
    reset = 1'b0;
    tick();
    n_tests++; if (s_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got=%b exp=1", s_rdy); end
  endtask

  task automatic test_single_read();
    int first;
    logic [N_DATA_BITS-1:0] got;
    ram[5] = 64'hAB;
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = AW'(5);
    tick();
    n_tests++; if (s_acc !== 1'b1) begin n_fail++; $display("FAIL single_accept got=%b exp=1", s_acc); end
    req_valid = 1'b0;
    first = -1; got = '0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (s_vld === 1'b1 && first < 0) begin first = k; got = s_data; end
    end
    n_tests++; if (first != LAT + 1) begin n_fail++; $display("FAIL single_latency got=%0d exp=%0d", first, LAT + 1); end
    n_tests++; if (got !== 64'hAB) begin n_fail++; $display("FAIL single_data got=%h exp=%h", got, 64'hAB); end
    n_tests++; if (s_idle !== 1'b1) begin n_fail++; $display("FAIL single_idle got=%b exp=1", s_idle); end
  endtask

  task automatic test_stream();
    int nrsp, first, last;
    bit all_rdy;
    for (int i = 0; i < 16; i++) ram[i] = N_DATA_BITS'(i);
    rsp_ready = 1'b1; nrsp = 0; first = -1; last = -1; all_rdy = 1'b1;
    for (int k = 0; k < 16 + LAT + 4; k++) begin
      req_valid = (k < 16); req_addr = AW'(k); req_tag_v = N_TAG_BITS'($urandom);
      tick();
      if (k < 16 && s_rdy !== 1'b1) all_rdy = 1'b0;
      if (s_pop) begin
        n_tests++;
        if (s_data !== N_DATA_BITS'(nrsp)) begin n_fail++; $display("FAIL stream_data got=%h exp=%h", s_data, N_DATA_BITS'(nrsp)); end
`ifdef CCI_MPF_PRIM_RAM_RD_STREAM_TAG_EN
        n_tests++;
        if (s_tag !== s_exp.tag) begin n_fail++; $display("FAIL stream_tag got=%h exp=%h", s_tag, s_exp.tag); end
`endif
        if (first < 0) first = k;
        last = k;
        nrsp++;
      end
    end
    n_tests++; if (all_rdy !== 1'b1) begin n_fail++; $display("FAIL stream_ready got=0 exp=1"); end
    n_tests++; if (nrsp != 16) begin n_fail++; $display("FAIL stream_count got=%0d exp=16", nrsp); end
    n_tests++; if (last - first != 15) begin n_fail++; $display("FAIL stream_consecutive got=%0d exp=15", last - first); end
  endtask

  task automatic test_backpressure();
    int nacc, npop;
    rsp_ready = 1'b0; nacc = 0;
    for (int k = 0; k < 10; k++) begin
      req_valid = 1'b1; req_addr = AW'($urandom); req_tag_v = N_TAG_BITS'($urandom);
      tick();
      if (s_acc) nacc++;
    end
    n_tests++; if (nacc != BUF) begin n_fail++; $display("FAIL bp_accepts got=%0d exp=%0d", nacc, BUF); end
    n_tests++; if (s_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got=%b exp=0", s_rdy); end
    req_valid = 1'b0; rsp_ready = 1'b1; npop = 0;
    tick();
    n_tests++; if (s_pop !== 1'b1) begin n_fail++; $display("FAIL bp_first_pop got=%b exp=1", s_pop); end
    n_tests++; if (s_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_ready_pop_cycle got=%b exp=0", s_rdy); end
    for (int k = 0; k < 10; k++) begin
      if (s_pop) begin
        npop++;
        n_tests++;
        if (s_spur || s_data !== s_exp.data) begin n_fail++; $display("FAIL bp_data got=%h exp=%h", s_data, s_exp.data); end
      end
      tick();
      if (k == 0) begin
        n_tests++; if (s_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_pop got=%b exp=1", s_rdy); end
      end
    end
    n_tests++; if (npop != BUF) begin n_fail++; $display("FAIL bp_drain_count got=%0d exp=%0d", npop, BUF); end
    n_tests++; if (s_idle !== 1'b1) begin n_fail++; $display("FAIL bp_idle got=%b exp=1", s_idle); end
  endtask

  task automatic test_concurrent();
    int npop;
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1; req_addr = AW'($urandom); req_tag_v = N_TAG_BITS'($urandom);
      tick();
    end
    req_valid = 1'b0;
    tick();
    rsp_ready = 1'b1;
    tick();
    n_tests++; if (s_pop !== 1'b1) begin n_fail++; $display("FAIL conc_pop got=%b exp=1", s_pop); end
    n_tests++; if (s_spur || s_data !== s_exp.data) begin n_fail++; $display("FAIL conc_data got=%h exp=%h", s_data, s_exp.data); end
    rsp_ready = 1'b0;
    tick();
    tick();
    n_tests++; if (s_idle !== 1'b0) begin n_fail++; $display("FAIL conc_held got=%b exp=0", s_idle); end
    rsp_ready = 1'b1; npop = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (s_pop) begin
        npop++;
        n_tests++;
        if (s_spur || s_data !== s_exp.data) begin n_fail++; $display("FAIL conc_drain_data got=%h exp=%h", s_data, s_exp.data); end
      end
    end
    n_tests++; if (npop != 2) begin n_fail++; $display("FAIL conc_remaining got=%0d exp=2", npop); end
    n_tests++; if (s_idle !== 1'b1) begin n_fail++; $display("FAIL conc_idle got=%b exp=1", s_idle); end
  endtask

  task automatic test_reset_midflight();
    int nvld, npop;
    logic [N_DATA_BITS-1:0] want;
    rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req_valid = 1'b1; req_addr = AW'($urandom); req_tag_v = N_TAG_BITS'($urandom);
      tick();
    end
    req_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0; rsp_ready = 1'b1; nvld = 0;
    tick();
    n_tests++; if (s_rdy !== 1'b1) begin n_fail++; $display("FAIL mid_ready_after_reset got=%b exp=1", s_rdy); end
    if (s_vld !== 1'b0) nvld++;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (s_vld !== 1'b0) nvld++;
    end
    n_tests++; if (nvld != 0) begin n_fail++; $display("FAIL mid_stale_rsp got=%0d exp=0", nvld); end
    n_tests++; if (s_idle !== 1'b1) begin n_fail++; $display("FAIL mid_idle got=%b exp=1", s_idle); end
    want = {$urandom, $urandom};
    ram[7] = want;
    req_valid = 1'b1; req_addr = AW'(7);
    tick();
    req_valid = 1'b0; npop = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (s_pop) begin
        npop++;
        n_tests++;
        if (s_data !== want) begin n_fail++; $display("FAIL mid_data got=%h exp=%h", s_data, want); end
      end
    end
    n_tests++; if (npop != 1) begin n_fail++; $display("FAIL mid_count got=%0d exp=1", npop); end
  endtask

`ifdef CCI_MPF_PRIM_RAM_RD_STREAM_TAG_EN
  task automatic test_tag();
    logic [N_TAG_BITS-1:0]  tags  [3];
    logic [N_DATA_BITS-1:0] datas [3];
    logic [AW-1:0]          a;
    int npop;
    tags[0] = 8'h11; tags[1] = 8'h22; tags[2] = 8'h33;
    rsp_ready = 1'b1; npop = 0;
    for (int k = 0; k < 10; k++) begin
      req_valid = (k < 3);
      if (k < 3) begin
        a = AW'($urandom); req_addr = a; req_tag_v = tags[k]; datas[k] = ram[a];
      end
      tick();
      if (s_pop && npop < 3) begin
        n_tests++;
        if (s_tag !== tags[npop]) begin n_fail++; $display("FAIL tag_value got=%h exp=%h", s_tag, tags[npop]); end
        n_tests++;
        if (s_data !== datas[npop]) begin n_fail++; $display("FAIL tag_data got=%h exp=%h", s_data, datas[npop]); end
        npop++;
      end
    end
    n_tests++; if (npop != 3) begin n_fail++; $display("FAIL tag_count got=%0d exp=3", npop); end
  endtask
`endif

  task automatic test_random();
    int lat;
    for (int k = 0; k < 400; k++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_addr  = AW'($urandom);
      req_tag_v = N_TAG_BITS'($urandom);
      rsp_ready = ($urandom_range(0, 2) != 0);
      tick();
      n_tests++; if (s_rdy !== s_exp_rdy) begin n_fail++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, s_rdy, s_exp_rdy); end
      n_tests++; if (s_idle !== s_exp_idle) begin n_fail++; $display("FAIL rand_idle cyc=%0d got=%b exp=%b", cyc, s_idle, s_exp_idle); end
      n_tests++; if (s_raddr !== req_addr) begin n_fail++; $display("FAIL rand_raddr got=%h exp=%h", s_raddr, req_addr); end
      if (s_pop) begin
        lat = cyc - 1 - s_exp.cyc;
        n_tests++;
        if (s_spur || s_data !== s_exp.data) begin n_fail++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, s_data, s_exp.data); end
        n_tests++;
        if (!s_spur && lat < LAT + 1) begin n_fail++; $display("FAIL rand_latency got=%0d exp>=%0d", lat, LAT + 1); end
`ifdef CCI_MPF_PRIM_RAM_RD_STREAM_TAG_EN
        n_tests++;
        if (s_tag !== s_exp.tag) begin n_fail++; $display("FAIL rand_tag got=%h exp=%h", s_tag, s_exp.tag); end
`endif
      end
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (s_pop) begin
        n_tests++;
        if (s_spur || s_data !== s_exp.data) begin n_fail++; $display("FAIL rand_drain_data got=%h exp=%h", s_data, s_exp.data); end
      end
    end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_undelivered got=%0d exp=0", exp_q.size()); end
    n_tests++; if (s_idle !== 1'b1) begin n_fail++; $display("FAIL rand_final_idle got=%b exp=1", s_idle); end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    for (int i = 0; i < N_ENTRIES; i++) ram[i] = {$urandom, $urandom};
    test_reset();
    test_single_read();
    test_stream();
    test_backpressure();
    test_concurrent();
    test_reset_midflight();
`ifdef CCI_MPF_PRIM_RAM_RD_STREAM_TAG_EN
    test_tag();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
